// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue, writeback request and register-file port bundle
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                   issue_valid_i;
  logic [ADDR_W-1:0]      issue_rd_i;
  logic [ADDR_W-1:0]      issue_rs1_i;
  logic [ADDR_W-1:0]      issue_rs2_i;
  logic                   issue_use_rs1_i;
  logic                   issue_use_rs2_i;
  logic                   issue_ready_o;
  logic                   alu_valid_i;
  logic [ADDR_W-1:0]      alu_addr_i;
  logic [DATA_W-1:0]      alu_data_i;
  logic                   alu_ready_o;
  logic                   lsu_valid_i;
  logic [ADDR_W-1:0]      lsu_addr_i;
  logic [DATA_W-1:0]      lsu_data_i;
  logic                   lsu_ready_o;
  logic                   rf_write_en_o;
  logic [ADDR_W-1:0]      rf_write_addr_o;
  logic [DATA_W-1:0]      rf_write_data_o;
  logic [2**ADDR_W-1:0]   busy_o;

  modport slave (
    input  issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
    input  issue_use_rs1_i, issue_use_rs2_i,
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    output issue_ready_o, alu_ready_o, lsu_ready_o,
    output rf_write_en_o, rf_write_addr_o, rf_write_data_o, busy_o
  );

  modport master (
    output issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
    output issue_use_rs1_i, issue_use_rs2_i,
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  issue_ready_o, alu_ready_o, lsu_ready_o,
    input  rf_write_en_o, rf_write_addr_o, rf_write_data_o, busy_o
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - ALU/LSU writeback arbiter, registered RF write port and hazard scoreboard
module regfile_wb_scheduler #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int RR_EN  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  regfile_wb_scheduler_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic              r_last_lsu;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREG-1:0]   r_busy;

  logic              w_gnt_alu;
  logic              w_gnt_lsu;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic [NREG-1:0]   w_clear;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_eff_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              w_issue_ok;
  logic              w_accept;

  // No grants while in reset, so nothing granted then is lost silently.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (!rst_i) begin
      if (bus.alu_valid_i && bus.lsu_valid_i) begin
        if (RR_EN != 0 && !r_last_lsu) w_gnt_lsu = 1'b1;
        else                           w_gnt_alu = 1'b1;
      end else begin
        w_gnt_alu = bus.alu_valid_i;
        w_gnt_lsu = bus.lsu_valid_i;
      end
    end
  end

  assign w_gnt_addr = w_gnt_lsu ? bus.lsu_addr_i : bus.alu_addr_i;
  assign w_gnt_data = w_gnt_lsu ? bus.lsu_data_i : bus.alu_data_i;

  always_comb begin
    w_clear = '0;
    w_set   = '0;
    if (r_we) w_clear[r_waddr] = 1'b1;
    if (w_accept && bus.issue_rd_i != '0) w_set[bus.issue_rd_i] = 1'b1;
  end

  // The RF bypass makes the port's data visible this cycle, so its clear is applied early.
  assign w_eff_busy = r_busy & ~w_clear;
  assign w_busy_nxt = w_eff_busy | w_set;

  assign w_issue_ok = !(bus.issue_use_rs1_i && w_eff_busy[bus.issue_rs1_i]) &&
                      !(bus.issue_use_rs2_i && w_eff_busy[bus.issue_rs2_i]) &&
                      !(bus.issue_rd_i != '0 && w_eff_busy[bus.issue_rd_i]);
  assign w_accept   = bus.issue_valid_i && w_issue_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_lsu <= 1'b1;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= '0;
    end else begin
      r_we    <= (w_gnt_alu || w_gnt_lsu) && (w_gnt_addr != '0);
      r_waddr <= w_gnt_addr;
      r_wdata <= w_gnt_data;
      if (w_gnt_alu || w_gnt_lsu) r_last_lsu <= w_gnt_lsu;
      r_busy  <= {w_busy_nxt[NREG-1:1], 1'b0};
    end
  end

  assign bus.issue_ready_o   = w_issue_ok;
  assign bus.alu_ready_o     = w_gnt_alu;
  assign bus.lsu_ready_o     = w_gnt_lsu;
  assign bus.rf_write_en_o   = r_we;
  assign bus.rf_write_addr_o = r_waddr;
  assign bus.rf_write_data_o = r_wdata;
  assign bus.busy_o          = r_busy;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler against a behavioural model
module tb_regfile_wb_scheduler;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  logic rst_fp;
  always #5 clk_i = ~clk_i;

  regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_fp ();

  regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RR_EN(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
  regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RR_EN(0)) u_fp (
    .clk_i(clk_i), .rst_i(rst_fp), .bus(bus_fp)
  );

  typedef struct {
    bit          rst;
    bit          av;
    logic [2:0]  aa;
    logic [15:0] ad;
    bit          lv;
    logic [2:0]  la;
    logic [15:0] ld;
    bit          iv;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    bit          u1;
    bit          u2;
  } stim_t;

  typedef struct {
    int          due;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  mon_en   = 0;
  wr_t expq[$];

  // Model state: in-flight destinations, the write now on the port, and who won last.
  bit         m_busy[NREG];
  bit         m_pv;
  logic [2:0] m_pa;
  bit         m_last_lsu;
  bit         m_ga;
  bit         m_gl;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    wr_t e;
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        check("wr_en", bus.rf_write_en_o, 1);
        check("wr_addr", bus.rf_write_addr_o, e.addr);
        check("wr_data", bus.rf_write_data_o, e.data);
      end else begin
        check("wr_en_idle", bus.rf_write_en_o, 0);
      end
    end
  end

  task automatic step(input stim_t s);
    bit          ga, gl, eir;
    bit          eff[NREG];
    logic [7:0]  exp_b;
    logic [2:0]  wa;
    logic [15:0] wd;
    wr_t         e;
    rst_i               = s.rst;
    bus.alu_valid_i     = s.av;
    bus.alu_addr_i      = s.aa;
    bus.alu_data_i      = s.ad;
    bus.lsu_valid_i     = s.lv;
    bus.lsu_addr_i      = s.la;
    bus.lsu_data_i      = s.ld;
    bus.issue_valid_i   = s.iv;
    bus.issue_rd_i      = s.rd;
    bus.issue_rs1_i     = s.rs1;
    bus.issue_rs2_i     = s.rs2;
    bus.issue_use_rs1_i = s.u1;
    bus.issue_use_rs2_i = s.u2;
    ga = 0;
    gl = 0;
    if (!s.rst) begin
      if (s.av && s.lv) begin
        ga = m_last_lsu;
        gl = !m_last_lsu;
      end else begin
        ga = s.av;
        gl = s.lv;
      end
    end
    for (int i = 0; i < NREG; i++) begin
      exp_b[i] = m_busy[i];
      eff[i]   = m_busy[i] && !(m_pv && m_pa == 3'(i));
    end
    eir = !(s.u1 && eff[s.rs1]) && !(s.u2 && eff[s.rs2]) && !(s.rd != 3'd0 && eff[s.rd]);
    @(negedge clk_i);
    check("alu_ready", bus.alu_ready_o, ga);
    check("lsu_ready", bus.lsu_ready_o, gl);
    check("issue_ready", bus.issue_ready_o, eir);
    check("busy", bus.busy_o, exp_b);
    wa = gl ? s.la : s.aa;
    wd = gl ? s.ld : s.ad;
    m_pv = (ga || gl) && wa != 3'd0;
    m_pa = wa;
    if (m_pv) begin
      e.due  = cyc + 1;
      e.addr = wa;
      e.data = wd;
      expq.push_back(e);
    end
    if (ga || gl) m_last_lsu = gl;
    for (int i = 0; i < NREG; i++) m_busy[i] = eff[i];
    if (s.iv && eir && s.rd != 3'd0) m_busy[s.rd] = 1;
    if (s.rst) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      m_pv       = 0;
      m_last_lsu = 1;
    end
    m_ga = ga;
    m_gl = gl;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    stim_t       s;
    stim_t       s0;
    bit          a_pend, l_pend;
    logic [2:0]  pa, pl;
    logic [15:0] pad, pld;
    s0 = '{default: 0};
    rst_i  = 1;
    rst_fp = 1;
    bus.issue_valid_i = 0; bus.issue_rd_i = 0; bus.issue_rs1_i = 0; bus.issue_rs2_i = 0;
    bus.issue_use_rs1_i = 0; bus.issue_use_rs2_i = 0;
    bus.alu_valid_i = 0; bus.alu_addr_i = 0; bus.alu_data_i = 0;
    bus.lsu_valid_i = 0; bus.lsu_addr_i = 0; bus.lsu_data_i = 0;
    bus_fp.issue_valid_i = 0; bus_fp.issue_rd_i = 0; bus_fp.issue_rs1_i = 0; bus_fp.issue_rs2_i = 0;
    bus_fp.issue_use_rs1_i = 0; bus_fp.issue_use_rs2_i = 0;
    bus_fp.alu_valid_i = 0; bus_fp.alu_addr_i = 0; bus_fp.alu_data_i = 0;
    bus_fp.lsu_valid_i = 0; bus_fp.lsu_addr_i = 0; bus_fp.lsu_data_i = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    m_pv = 0; m_pa = 0; m_last_lsu = 1; m_ga = 0; m_gl = 0;
    @(posedge clk_i);
    #1;
    mon_en = 1;

    // Reset with both requesters valid: no grants, empty scoreboard.
    s = s0; s.rst = 1;
    s.av = 1; s.aa = 3; s.ad = 16'h1111;
    s.lv = 1; s.la = 5; s.ld = 16'h2222;
    step(s);
    step(s);

    // Held conflict alternates ALU, LSU, ALU, LSU.
    s.rst = 0;
    for (int k = 0; k < 4; k++) step(s);
    step(s0);

    // RAW stall released in the same cycle the producer's write hits the port.
    s = s0; s.iv = 1; s.rd = 4; step(s);
    s = s0; s.iv = 1; s.rs1 = 4; s.u1 = 1; step(s);
    s.lv = 1; s.la = 4; s.ld = 16'hBEEF; step(s);
    s.lv = 0; step(s);
    step(s0);
    check("raw_busy4_cleared", bus.busy_o[4], 0);

    // WAW stall on r2, then drain it.
    s = s0; s.iv = 1; s.rd = 2; step(s);
    step(s);
    s = s0; s.av = 1; s.aa = 2; s.ad = 16'h1234; step(s);
    step(s0);

    // Writeback of r6 coincides with a new issue to r6: it stays busy.
    s = s0; s.iv = 1; s.rd = 6; step(s);
    s = s0; s.av = 1; s.aa = 6; s.ad = 16'h6666; step(s);
    s = s0; s.iv = 1; s.rd = 6; step(s);
    check("set_wins_busy6", bus.busy_o[6], 1);

    // r0 writes are consumed but never reach the port; rd=0 is no destination.
    s = s0; s.av = 1; s.aa = 0; s.ad = 16'hFFFF; step(s);
    step(s0);
    s = s0; s.iv = 1; s.rd = 0; step(s);
    check("r0_busy_unchanged", bus.busy_o, 8'h40);

    // Reset one cycle after a grant.
    s = s0; s.av = 1; s.aa = 7; s.ad = 16'h00AA; s.iv = 1; s.rd = 7; step(s);
    s = s0; s.rst = 1; s.av = 1; s.aa = 5; s.ad = 16'h5555; step(s);
    check("reset_mid_wr_en", bus.rf_write_en_o, 0);
    check("reset_mid_busy", bus.busy_o, 0);
    step(s0);

    // Randomised traffic with handshake-held requests and rare resets.
    a_pend = 0; l_pend = 0; pa = 0; pl = 0; pad = 0; pld = 0;
    for (int k = 0; k < 400; k++) begin
      if (!a_pend && $urandom_range(0, 2) != 0) begin
        a_pend = 1; pa = 3'($urandom_range(0, 7)); pad = 16'($urandom);
      end
      if (!l_pend && $urandom_range(0, 2) != 0) begin
        l_pend = 1; pl = 3'($urandom_range(0, 7)); pld = 16'($urandom);
      end
      s = s0;
      s.rst = ($urandom_range(0, 63) == 0);
      s.av = a_pend; s.aa = pa; s.ad = pad;
      s.lv = l_pend; s.la = pl; s.ld = pld;
      s.iv  = 1'($urandom_range(0, 1));
      s.rd  = 3'($urandom_range(0, 7));
      s.rs1 = 3'($urandom_range(0, 7));
      s.rs2 = 3'($urandom_range(0, 7));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      step(s);
      if (m_ga) a_pend = 0;
      if (m_gl) l_pend = 0;
    end
    step(s0);
    step(s0);
    check("queue_drained", expq.size(), 0);

    // Fixed-priority instance: ALU wins every cycle of a held conflict.
    rst_fp = 0;
    bus_fp.alu_valid_i = 1; bus_fp.alu_addr_i = 3; bus_fp.alu_data_i = 16'h1111;
    bus_fp.lsu_valid_i = 1; bus_fp.lsu_addr_i = 5; bus_fp.lsu_data_i = 16'h2222;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("fp_alu_ready", bus_fp.alu_ready_o, 1);
      check("fp_lsu_ready", bus_fp.lsu_ready_o, 0);
      if (k > 0) begin
        check("fp_wr_en", bus_fp.rf_write_en_o, 1);
        check("fp_wr_addr", bus_fp.rf_write_addr_o, 3);
        check("fp_wr_data", bus_fp.rf_write_data_o, 16'h1111);
      end
      @(posedge clk_i);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler and scoreboard for the 8 x 16-bit register file (r0 reads as zero; same-cycle write-to-read bypass). Shares the register file's single write port between the ALU and load/store writeback sources with round-robin arbitration, drives the port from a registered output stage, and tracks in-flight destinations in a scoreboard. The scoreboard stalls issue on RAW and WAW hazards.

## Interface
- DATA_W, 16, writeback data width
- ADDR_W, 3, register address width; 2**ADDR_W registers, r0 hardwired zero
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, ALU wins

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- issue_valid_i  in  1  decode stage presents an instruction
- issue_rd_i  in  ADDR_W  destination register; 0 = no destination
- issue_rs1_i, issue_rs2_i  in  ADDR_W  source registers
- issue_use_rs1_i, issue_use_rs2_i  in  1  source operand is actually read
- issue_ready_o  out  1  no hazard; issue is accepted when issue_valid_i and issue_ready_o are both 1
- alu_valid_i  in  1  ALU writeback request
- alu_addr_i  in  ADDR_W  ALU destination
- alu_data_i  in  DATA_W  ALU result
- alu_ready_o  out  1  ALU request granted this cycle
- lsu_valid_i  in  1  LSU writeback request
- lsu_addr_i  in  ADDR_W  LSU destination
- lsu_data_i  in  DATA_W  LSU data
- lsu_ready_o  out  1  LSU request granted this cycle
- rf_write_en_o  out  1  register-file write enable (registered)
- rf_write_addr_o  out  ADDR_W  register-file write address (registered)
- rf_write_data_o  out  DATA_W  register-file write data (registered)
- busy_o  out  2**ADDR_W  scoreboard bits; bit 0 is always 0

## Operation
- **Arbitration**
  - Combinational grant from the valids and the last_grant flop.
  - Only one requester valid: that requester is granted.
  - Both valid with RR_EN=1: the requester not granted last is granted.
  - Both valid with RR_EN=0: ALU is granted.
  - last_grant updates only on a cycle with a grant. It holds otherwise.
  - A request holds its valid, addr and data stable until it sees ready (valid/ready handshake). The losing requester stays valid.
- **Output stage**
  - The output stage loads every cycle; there is no backpressure from the register file.
  - rf_write_en_o <= granted & (granted addr != 0).
  - rf_write_addr_o and rf_write_data_o load from the granted requester.
  - A granted write to r0 is consumed (ready=1) but never drives rf_write_en_o.
- **Scoreboard (busy bits)**
  - Set: busy[issue_rd_i] on an accepted issue with issue_rd_i != 0.
  - Clear: busy[rf_write_addr_o] on a cycle with rf_write_en_o = 1.
  - Set and clear on the same register in the same cycle: set wins, because the new producer is in flight.
  - A writeback to a register that is not busy is written normally; the clear is a no-op.
- **Hazard check**
  - eff_busy = busy & ~clear_vec, where clear_vec is this cycle's rf_write clear.
  - eff_busy is used because the register file bypass makes the data visible in the same cycle.
  - issue_ready_o = !(use_rs1 & eff_busy[rs1]) & !(use_rs2 & eff_busy[rs2]) & !(rd != 0 & eff_busy[rd]).
  - issue_ready_o is combinational and is independent of issue_valid_i.

## Timing
- **Reset values**
  - rf_write_en_o = 0, rf_write_addr_o = 0, rf_write_data_o = 0.
  - busy_o = 0.
  - last_grant = LSU, so the ALU wins the first conflict.
  - issue_ready_o = 1.
  - alu_ready_o and lsu_ready_o follow the valids.
- **Latency**
  - Grant to rf_write_en_o: 1 cycle.
  - Issue accept to busy bit visible: 1 cycle.
  - rf_write_en_o to the dependent issue_ready_o rising: 0 cycles (same cycle).
- **Reset mid-operation**
  - The registered write in flight is dropped (rf_write_en_o = 0 the cycle after reset is asserted).
  - All busy bits clear.
  - Grants asserted during reset are ignored; alu_ready_o and lsu_ready_o are forced to 0 while rst_i = 1.
- **Throughput:** one register-file write per cycle. With both sources continuously valid and RR_EN=1, grants strictly alternate.

## Test plan
- **Reset:** rst_i for 2 cycles with both valids high → rf_write_en_o = 0, busy_o = 0, both ready = 0. On the first cycle after release, alu_ready_o = 1 and lsu_ready_o = 0.
- **Round-robin conflict:** ALU (r3, 0x1111) and LSU (r5, 0x2222) valid and held. Cycle 0: ALU is granted. Cycle 1: LSU is granted. Port shows r3/0x1111 then r5/0x2222 on consecutive cycles. With RR_EN=0 and both held, the ALU is granted every cycle.
- **RAW stall:** issue rd=r4 is accepted. Next cycle, issue with rs1=r4 and use_rs1=1 → issue_ready_o = 0. LSU writes r4 = 0xBEEF; issue_ready_o = 1 in the same cycle that rf_write_en_o = 1 with addr 4. busy_o[4] = 0 on the next cycle.
- **WAW and set-wins:** r2 is busy. Issue with rd=r2 → stalled. In a separate case, r6 writeback and a new issue of rd=r6 occur in the same cycle → busy_o[6] remains 1.
- **r0 handling:** ALU writes r0 = 0xFFFF → alu_ready_o = 1 and rf_write_en_o stays 0. Issue with rd=0 → busy_o unchanged and issue_ready_o is not blocked by rd.
- **Reset mid-flight:** grant ALU r7 = 0x00AA. Assert rst_i in the next cycle → rf_write_en_o = 0 and busy_o = 0 on the cycle after.
